// File: rtl/ring_digit_scanner.sv
// Time-multiplexed N-digit 7-segment driver fed by a one-hot ring-counter phase,
// with sticky one-hot / step-sequence error flags and a ring revolution counter.
// Ports: clk, rst (async active-low); phase/digits/blank/err_clr in;
//        an/seg (active-low, registered), phase_err, seq_err, rev_tick, rev_cnt out.
// Latency: 1 cycle from sampled inputs to an/seg/flags/counter. No backpressure.
module ring_digit_scanner #(
  parameter int N     = 4,
  parameter int DIR   = 0,
  parameter int REV_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       phase,
  input  logic [4*N-1:0]     digits,
  input  logic [N-1:0]       blank,
  input  logic               err_clr,
  output logic [N-1:0]       an,
  output logic [6:0]         seg,
  output logic               phase_err,
  output logic               seq_err,
  output logic               rev_tick,
  output logic [REV_W-1:0]   rev_cnt
);

  localparam int IW        = (N > 1) ? $clog2(N) : 1;
  // The ring "ends" on the bit it leaves when wrapping back to the start bit.
  localparam int END_BIT   = (DIR == 0) ? N - 1 : 0;
  localparam int START_BIT = (DIR == 0) ? 0 : N - 1;

  logic [N-1:0]  prev_phase;
  logic          hist_valid;
  logic          valid;
  logic [IW-1:0] idx;
  logic [3:0]    digit;
  logic [N-1:0]  rot_prev;
  logic          step_bad;
  logic          wrap;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign valid = (phase != '0) && ((phase & (phase - N'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (phase[i]) idx = IW'(i);
    end
  end

  assign digit = digits[4*idx +: 4];

  generate
    if (DIR == 0) begin : g_rot_left
      assign rot_prev = {prev_phase[N-2:0], prev_phase[N-1]};
    end else begin : g_rot_right
      assign rot_prev = {prev_phase[0], prev_phase[N-1:1]};
    end
  endgenerate

  assign step_bad = valid && hist_valid && (phase != prev_phase) && (phase != rot_prev);
  // For N>=2, end bit followed by start bit is always the legal rotation.
  assign wrap     = valid && hist_valid && prev_phase[END_BIT] && phase[START_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= '1;
      seg        <= 7'h7F;
      phase_err  <= 1'b0;
      seq_err    <= 1'b0;
      rev_tick   <= 1'b0;
      rev_cnt    <= '0;
      prev_phase <= '0;
      hist_valid <= 1'b0;
    end else begin
      if (valid && !blank[idx]) begin
        an  <= ~phase;
        seg <= hex7(digit);
      end else begin
        an  <= '1;
        seg <= 7'h7F;
      end
      // A new error in the clear cycle wins over the clear.
      phase_err <= !valid || (phase_err && !err_clr);
      seq_err   <= step_bad || (seq_err && !err_clr);
      if (valid) prev_phase <= phase;
      if (err_clr)    hist_valid <= 1'b0;
      else if (valid) hist_valid <= 1'b1;
      rev_tick <= wrap;
      if (wrap) rev_cnt <= rev_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_digit_scanner.sv
module tb_ring_digit_scanner;
  localparam int N = 4;
  localparam int DIR = 0;
  localparam int REV_W = 8;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 0;
  logic rst = 0;
  logic [N-1:0] phase = '0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0] blank = '0;
  logic err_clr = 0;
  logic [N-1:0] an;
  logic [6:0] seg;
  logic phase_err, seq_err, rev_tick;
  logic [REV_W-1:0] rev_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state (index-based, not bit-vector based)
  int  m_prev_idx;
  bit  m_hist;
  bit  m_perr, m_serr, m_tick;
  int  m_cnt;
  logic [N-1:0] exp_an;
  logic [6:0] exp_seg;

  always #5 clk = ~clk;

  ring_digit_scanner #(.N(N), .DIR(DIR), .REV_W(REV_W)) dut (
    .clk(clk), .rst(rst), .phase(phase), .digits(digits), .blank(blank),
    .err_clr(err_clr), .an(an), .seg(seg), .phase_err(phase_err),
    .seq_err(seq_err), .rev_tick(rev_tick), .rev_cnt(rev_cnt)
  );

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_prev_idx = 0; m_hist = 0; m_perr = 0; m_serr = 0; m_tick = 0; m_cnt = 0;
    exp_an = '1; exp_seg = 7'h7F;
  endtask

  // Drive one sample, update the model, advance past the edge.
  task automatic tick(input logic [N-1:0] ph, input logic [4*N-1:0] dg,
                      input logic [N-1:0] bl, input logic clr);
    bit v, bad, wr;
    int idx, nxt, end_i, start_i;
    logic [3:0] d;
    phase = ph; digits = dg; blank = bl; err_clr = clr;
    v = ($countones(ph) == 1);
    idx = 0;
    for (int i = 0; i < N; i++) if (ph[i]) idx = i;
    nxt = (DIR == 0) ? (m_prev_idx + 1) % N : (m_prev_idx + N - 1) % N;
    end_i = (DIR == 0) ? N - 1 : 0;
    start_i = (DIR == 0) ? 0 : N - 1;
    if (v && !bl[idx]) begin
      d = dg[4*idx +: 4];
      exp_an = ~ph;
      exp_seg = HEX[d];
    end else begin
      exp_an = '1;
      exp_seg = 7'h7F;
    end
    bad = v && m_hist && !(idx == m_prev_idx || idx == nxt);
    wr = v && m_hist && m_prev_idx == end_i && idx == start_i;
    m_perr = !v ? 1'b1 : (clr ? 1'b0 : m_perr);
    m_serr = bad ? 1'b1 : (clr ? 1'b0 : m_serr);
    if (clr) m_hist = 0; else if (v) m_hist = 1;
    if (v) m_prev_idx = idx;
    m_tick = wr;
    if (wr) m_cnt = (m_cnt + 1) % (1 << REV_W);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; phase = '0; blank = '0; err_clr = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tick(4'b0001, 16'h1234, '0, 0);
    tick(4'b0100, 16'h1234, '0, 0);   // seq_err
    tick(4'b0000, 16'h1234, '0, 0);   // phase_err
    #2 rst = 0;
    #1;
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if ({phase_err, seq_err, rev_tick} !== 3'b000)
      begin failures++; $display("FAIL reset_flags got=%b exp=000", {phase_err, seq_err, rev_tick}); end
    checks++; if (rev_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", rev_cnt); end
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_rotate();
    logic [N-1:0] ph [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] an_e [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_e [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
    for (int k = 0; k < 5; k++) begin
      tick(ph[k], 16'h1234, '0, 0);
      checks++; if (an !== an_e[k]) begin failures++; $display("FAIL rot_an k=%0d got=%b exp=%b", k, an, an_e[k]); end
      checks++; if (seg !== seg_e[k]) begin failures++; $display("FAIL rot_seg k=%0d got=%h exp=%h", k, seg, seg_e[k]); end
      checks++; if (rev_tick !== (k == 4)) begin failures++; $display("FAIL rot_tick k=%0d got=%b exp=%b", k, rev_tick, k == 4); end
    end
    checks++; if (rev_cnt !== 8'd1) begin failures++; $display("FAIL rot_cnt got=%0d exp=1", rev_cnt); end
    tick(4'b0001, 16'h1234, '0, 0);
    checks++; if (rev_tick !== 1'b0) begin failures++; $display("FAIL rot_tick_pulse got=%b exp=0", rev_tick); end
    checks++; if (seq_err !== 1'b0 || phase_err !== 1'b0)
      begin failures++; $display("FAIL rot_flags got=%b%b exp=00", phase_err, seq_err); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(4'b0001, 16'hABCD, '0, 0);
    for (int k = 0; k < 3; k++) tick(4'b0010, 16'hABCD, '0, 0);
    tick(4'b0100, 16'hABCD, '0, 0);
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL stall_seq got=%b exp=0", seq_err); end
    checks++; if (seg !== 7'h03) begin failures++; $display("FAIL stall_seg got=%h exp=03", seg); end
    // Stalling on the end bit must not tick; leaving it to start must.
    tick(4'b1000, 16'hABCD, '0, 0);
    tick(4'b1000, 16'hABCD, '0, 0);
    checks++; if (rev_tick !== 1'b0) begin failures++; $display("FAIL stall_end_tick got=%b exp=0", rev_tick); end
    tick(4'b0001, 16'hABCD, '0, 0);
    checks++; if (rev_tick !== 1'b1 || rev_cnt !== 8'd1)
      begin failures++; $display("FAIL stall_wrap got=%b/%0d exp=1/1", rev_tick, rev_cnt); end
  endtask

  task automatic test_skip_clear();
    do_reset();
    tick(4'b0001, 16'h1234, '0, 0);
    tick(4'b0100, 16'h1234, '0, 0);
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL skip_set got=%b exp=1", seq_err); end
    tick(4'b0100, 16'h1234, '0, 0);
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL skip_hold got=%b exp=1", seq_err); end
    tick(4'b0100, 16'h1234, '0, 1);
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL skip_clr got=%b exp=0", seq_err); end
    tick(4'b0001, 16'h1234, '0, 0);
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL skip_first_after_clr got=%b exp=0", seq_err); end
    // Set wins over a simultaneous clear.
    tick(4'b0100, 16'h1234, '0, 1);
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL skip_set_wins got=%b exp=1", seq_err); end
    tick(4'b0000, 16'h1234, '0, 1);
    checks++; if (phase_err !== 1'b1 || seq_err !== 1'b0)
      begin failures++; $display("FAIL perr_set_wins got=%b%b exp=10", phase_err, seq_err); end
  endtask

  task automatic test_phase_err();
    logic [N-1:0] bad [2] = '{4'b0000, 4'b0011};
    do_reset();
    tick(4'b0001, 16'h5678, '0, 0);
    for (int k = 0; k < 2; k++) begin
      tick(bad[k], 16'h5678, '0, 0);
      checks++; if (phase_err !== 1'b1) begin failures++; $display("FAIL perr k=%0d got=%b exp=1", k, phase_err); end
      checks++; if (an !== 4'hF || seg !== 7'h7F)
        begin failures++; $display("FAIL perr_dark k=%0d got=%h/%h exp=f/7f", k, an, seg); end
    end
    // History unchanged by invalid samples: 0001 -> 0010 still legal.
    tick(4'b0010, 16'h5678, '0, 0);
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL perr_hist got=%b exp=0", seq_err); end
  endtask

  task automatic test_blank();
    do_reset();
    tick(4'b0100, 16'h1234, 4'b0100, 0);
    checks++; if (an !== 4'hF || seg !== 7'h7F)
      begin failures++; $display("FAIL blank_dark got=%h/%h exp=f/7f", an, seg); end
    tick(4'b1000, 16'h1234, 4'b0100, 0);
    checks++; if (an !== 4'b0111 || seg !== 7'h79)
      begin failures++; $display("FAIL blank_next got=%b/%h exp=0111/79", an, seg); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL blank_seq got=%b exp=0", seq_err); end
  endtask

  task automatic test_rev_wrap();
    do_reset();
    for (int k = 0; k < 257 * N + 1; k++) begin
      tick(oh(k % N), 16'h0F0F, '0, 0);
      checks++; if (rev_tick !== m_tick || rev_cnt !== m_cnt[REV_W-1:0])
        begin failures++; $display("FAIL wrap k=%0d got=%b/%0d exp=%b/%0d", k, rev_tick, rev_cnt, m_tick, m_cnt); end
    end
    checks++; if (rev_cnt !== 8'd1) begin failures++; $display("FAIL wrap_final got=%0d exp=1", rev_cnt); end
  endtask

  task automatic test_random();
    int cur;
    int r;
    logic [N-1:0] ph;
    do_reset();
    cur = 0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin cur = (DIR == 0) ? (cur + 1) % N : (cur + N - 1) % N; ph = oh(cur); end
      else if (r < 80) ph = oh(cur);
      else if (r < 90) begin cur = $urandom_range(0, N - 1); ph = oh(cur); end
      else ph = N'($urandom);
      tick(ph, 16'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
           $urandom_range(0, 15) == 0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || phase_err !== m_perr || seq_err !== m_serr ||
          rev_tick !== m_tick || rev_cnt !== m_cnt[REV_W-1:0]) begin
        failures++;
        $display("FAIL rand k=%0d got an=%b seg=%h pe=%b se=%b t=%b c=%0d exp an=%b seg=%h pe=%b se=%b t=%b c=%0d",
                 k, an, seg, phase_err, seq_err, rev_tick, rev_cnt,
                 exp_an, exp_seg, m_perr, m_serr, m_tick, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    #12 rst = 1;
    test_reset();
    test_rotate();
    test_stall();
    test_skip_clear();
    test_phase_err();
    test_blank();
    test_rev_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
